pcie_s10_msi_arb: RTL and testbench
===================================

PCIE_S10_MSI_ARB -- requirements
Module: pcie_s10_msi_arb

Interface
REQ-001 SHALL have parameter MSI_COUNT, default 32: number of interrupt sources, legal range 1-32.
REQ-002 SHALL have parameter FUNC_NUM, default 0: value driven on app_msi_func_num, legal range 0-3.
REQ-003 SHALL have parameter TC, default 0: traffic class driven on app_msi_tc.
REQ-004 SHALL be fully synchronous to one clock, with an asynchronous active-low reset.
REQ-005 clk  in  1  clock; all logic samples on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 msi_irq  in  MSI_COUNT  interrupt sources; a request is the 0->1 edge of a bit.
REQ-008 cfg_msi_enable  in  1  MSI Enable bit of the function.
REQ-009 cfg_multiple_msi_enable  in  3  Multiple Message Enable field; allowed vector count = 2^value, capped at 32.
REQ-010 cfg_msi_mask  in  32  per-vector mask bits.
REQ-011 app_msi_req  out  1  request to the hard IP.
REQ-012 app_msi_ack  in  1  single-cycle acknowledge from the hard IP.
REQ-013 app_msi_num  out  5  vector number being sent.
REQ-014 app_msi_func_num  out  2  function number, tied to FUNC_NUM.
REQ-015 app_msi_tc  out  3  traffic class, tied to TC.
REQ-016 app_msi_status  in  2  completion status, valid with app_msi_ack; 2'b00 = success, any other value = error.
REQ-017 msi_err_count  out  8  count of failed sends, saturating.

Function
REQ-018 SHALL register msi_irq once and set pending[i] on the cycle after an edge is detected on bit i; a held-high level SHALL NOT set pending again.
REQ-019 SHALL fold source i onto vector v = i & (allowed_count-1).
REQ-020 Source i SHALL be eligible when pending[i]=1, cfg_msi_enable=1 and cfg_msi_mask[v]=0.
REQ-021 A masked or disabled source SHALL stay pending and SHALL be sent once it becomes eligible.
REQ-022 SHALL select among eligible sources round-robin.
    - The search starts at the index one above the last granted index and wraps from MSI_COUNT-1 back to 0.
REQ-023 FSM states:
    - IDLE: if any source is eligible, latch its index and vector, assert app_msi_req on the next cycle, go to REQ.
    - REQ: hold app_msi_req and app_msi_num stable until app_msi_ack=1.
    - REQ -> GAP on ack: clear the granted pending bit if status is 2'b00; otherwise leave it set and increment msi_err_count.
    - GAP: one idle cycle, then IDLE. app_msi_req is low for at least 1 cycle between requests.
REQ-024 Latency: an msi_irq edge sampled in cycle N, with the block idle and the source eligible, SHALL give app_msi_req=1 in cycle N+3.
REQ-025 Once asserted, app_msi_req SHALL NOT be withdrawn before ack, even if cfg_msi_enable drops or the vector becomes masked.
REQ-026 If a new edge on a source and the clear of that same source occur in the same cycle, the set SHALL win and the source stays pending.
REQ-027 app_msi_ack received outside the REQ state SHALL be ignored.
REQ-028 msi_err_count SHALL saturate at 8'hFF.

Reset
REQ-029 When rst_n is low, SHALL asynchronously clear all of the following and hold them cleared until rst_n goes high:
    - pending, the edge-detect register and msi_err_count;
    - the FSM (to IDLE) and the round-robin pointer (so index 0 has highest priority first);
    - app_msi_req and app_msi_num.
REQ-030 app_msi_func_num and app_msi_tc SHALL equal their parameter values at all times, including during reset.
REQ-031 Reset asserted during REQ SHALL drop app_msi_req immediately, and the in-flight source SHALL be lost.

Structure
REQ-032 The FSM state encodings and the MSI status codes (STATUS_OK=2'b00) SHALL be localparams in the shared pcie_s10 constants package.
REQ-033 Round-robin selection SHALL use one sub-module, arbiter, configured for round-robin priority with a one-hot grant output.

Verification
REQ-034 Setup MSI_COUNT=32, enable=1, multiple_msi_enable=5, mask=0. Pulse irq[3] in cycle 10 -> app_msi_req=1 in cycle 13 with app_msi_num=3. Ack with status 00 -> pending[3] cleared and app_msi_req=0 for at least 1 cycle.
REQ-035 Pulse irq[1], irq[2] and irq[30] in the same cycle -> sends are vectors 1, 2, 30 in that order. Then pulse irq[1] and irq[2] together -> the next grant is 1 after the pointer wraps past 30.
REQ-036 Set multiple_msi_enable=2 (4 vectors) and pulse irq[13] -> app_msi_num=1.
REQ-037 Set mask[5]=1 and pulse irq[5] -> no request for 100 cycles. Clear mask[5] -> request with vector 5 within 3 cycles.
REQ-038 Two consecutive acks with status 2'b10 -> vector re-sent each time, msi_err_count=2. A third ack with status 00 -> pending cleared, msi_err_count=2.
REQ-039 Drop enable while app_msi_req=1 -> req held until ack. Assert rst_n=0 mid-REQ -> app_msi_req=0 in the same cycle and msi_err_count=0.

Source files
------------

// File: rtl/pcie_s10_msi_arb_pkg.sv
// Shared constants for the Stratix 10 PCIe MSI arbiter: FSM encodings,
// completion status codes and the source-to-vector folding helper.
package pcie_s10_msi_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] STATUS_OK = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_GAP  = ST_GAP
  } msi_state_e;

  // Multiple Message Enable grants 2^mme vectors; anything above 5 caps at 32.
  function automatic logic [4:0] fold_vec(input logic [4:0] idx, input logic [2:0] mme);
    logic [4:0] vmask;
    case (mme)
      3'd0:    vmask = 5'h00;
      3'd1:    vmask = 5'h01;
      3'd2:    vmask = 5'h03;
      3'd3:    vmask = 5'h07;
      3'd4:    vmask = 5'h0F;
      default: vmask = 5'h1F;
    endcase
    return idx & vmask;
  endfunction

endpackage

// File: rtl/pcie_s10_msi_arb_arbiter.sv
// Round-robin (or fixed-priority) arbiter with one-hot grant; the pointer
// advances only when the grant is taken.
module pcie_s10_msi_arb_arbiter #(
  parameter int unsigned N           = 32,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         take,
  output logic [N-1:0] grant_oh
);

  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  logic [IDXW-1:0] last_q, last_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant_oh = '0;
    last_d   = last_q;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = ROUND_ROBIN ? (32'(last_q) + off) : (off - 1);
      if (idx >= N) idx = idx - N;
      if (!found && req[IDXW'(idx)]) begin
        found                 = 1'b1;
        grant_oh[IDXW'(idx)]  = 1'b1;
        last_d                = IDXW'(idx);
      end
    end
    if (!take) last_d = last_q;
  end

  // Reset pointer to the top index so the search starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDXW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/pcie_s10_msi_arb.sv
// MSI request arbiter: edge-detects interrupt sources, folds them onto the
// enabled vector count and issues one app_msi request at a time.
module pcie_s10_msi_arb
  import pcie_s10_msi_arb_pkg::*;
#(
  parameter int unsigned MSI_COUNT = 32,
  parameter int unsigned FUNC_NUM  = 0,
  parameter int unsigned TC        = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MSI_COUNT-1:0] msi_irq,
  input  logic                 cfg_msi_enable,
  input  logic [2:0]           cfg_multiple_msi_enable,
  input  logic [31:0]          cfg_msi_mask,
  output logic                 app_msi_req,
  input  logic                 app_msi_ack,
  output logic [4:0]           app_msi_num,
  output logic [1:0]           app_msi_func_num,
  output logic [2:0]           app_msi_tc,
  input  logic [1:0]           app_msi_status,
  output logic [7:0]           msi_err_count
);

  localparam int unsigned IDXW = (MSI_COUNT > 1) ? $clog2(MSI_COUNT) : 1;

  msi_state_e             state_q, state_d;
  logic [MSI_COUNT-1:0]   irq_q, irq_qq;
  logic [MSI_COUNT-1:0]   pending_q, pending_d;
  logic [MSI_COUNT-1:0]   edge_det, eligible, grant_oh, clr;
  logic                   req_q, req_d;
  logic [4:0]             num_q, num_d;
  logic [IDXW-1:0]        idx_q, idx_d, gidx;
  logic [7:0]             err_q, err_d;

  assign app_msi_func_num = 2'(FUNC_NUM);
  assign app_msi_tc       = 3'(TC);
  assign app_msi_req      = req_q;
  assign app_msi_num      = num_q;
  assign msi_err_count    = err_q;

  assign edge_det = irq_q & ~irq_qq;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < MSI_COUNT; i++) begin
      eligible[i] = pending_q[i] & cfg_msi_enable
                  & ~cfg_msi_mask[fold_vec(5'(i), cfg_multiple_msi_enable)];
    end
  end

  pcie_s10_msi_arb_arbiter #(
    .N           (MSI_COUNT),
    .ROUND_ROBIN (1'b1)
  ) u_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (eligible),
    .take     (state_q == S_IDLE),
    .grant_oh (grant_oh)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < MSI_COUNT; i++) begin
      if (grant_oh[i]) gidx = gidx | IDXW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    num_d   = num_q;
    idx_d   = idx_q;
    err_d   = err_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          idx_d   = gidx;
          num_d   = fold_vec(5'(gidx), cfg_multiple_msi_enable);
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (app_msi_ack) begin
          req_d   = 1'b0;
          state_d = S_GAP;
          if (app_msi_status == STATUS_OK) clr[idx_q] = 1'b1;
          else if (err_q != 8'hFF)         err_d = err_q + 8'd1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
    // A fresh edge outranks the clear of the same source.
    pending_d = (pending_q & ~clr) | edge_det;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      irq_q     <= '0;
      irq_qq    <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      num_q     <= '0;
      idx_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= msi_irq;
      irq_qq    <= irq_q;
      pending_q <= pending_d;
      req_q     <= req_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_pcie_s10_msi_arb.sv
// Self-checking bench for pcie_s10_msi_arb: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_pcie_s10_msi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] msi_irq = '0;
  logic        cfg_msi_enable = 1'b0;
  logic [2:0]  cfg_multiple_msi_enable = 3'd0;
  logic [31:0] cfg_msi_mask = '0;
  logic        app_msi_req;
  logic        app_msi_ack = 1'b0;
  logic [4:0]  app_msi_num;
  logic [1:0]  app_msi_func_num;
  logic [2:0]  app_msi_tc;
  logic [1:0]  app_msi_status = 2'b00;
  logic [7:0]  msi_err_count;

  int n_checks = 0;
  int n_errs   = 0;

  pcie_s10_msi_arb #(
    .MSI_COUNT (32),
    .FUNC_NUM  (2),
    .TC        (5)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .msi_irq                 (msi_irq),
    .cfg_msi_enable          (cfg_msi_enable),
    .cfg_multiple_msi_enable (cfg_multiple_msi_enable),
    .cfg_msi_mask            (cfg_msi_mask),
    .app_msi_req             (app_msi_req),
    .app_msi_ack             (app_msi_ack),
    .app_msi_num             (app_msi_num),
    .app_msi_func_num        (app_msi_func_num),
    .app_msi_tc              (app_msi_tc),
    .app_msi_status          (app_msi_status),
    .msi_err_count           (msi_err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pend, m_prev, m_dly;
  bit          m_busy, m_gap;
  int          m_cur, m_vec, m_last, m_err;

  function automatic int fold(input int i, input logic [2:0] mme);
    int cnt;
    cnt = (mme >= 5) ? 32 : (1 << mme);
    return i & (cnt - 1);
  endfunction

  task automatic model_step();
    logic [31:0] newe, setv;
    int clr;
    bit found;
    int i;
    newe   = msi_irq & ~m_prev;
    m_prev = msi_irq;
    setv   = m_dly;
    m_dly  = newe;
    clr    = -1;
    if (m_busy) begin
      if (app_msi_ack) begin
        if (app_msi_status == 2'b00) clr = m_cur;
        else if (m_err < 255) m_err++;
        m_busy = 0;
        m_gap  = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      found = 0;
      for (int off = 1; off <= 32; off++) begin
        i = (m_last + off) % 32;
        if (!found && m_pend[i] && cfg_msi_enable &&
            !cfg_msi_mask[fold(i, cfg_multiple_msi_enable)]) begin
          found  = 1;
          m_busy = 1;
          m_cur  = i;
          m_vec  = fold(i, cfg_multiple_msi_enable);
          m_last = i;
        end
      end
    end
    if (clr >= 0) m_pend[clr] = 1'b0;
    m_pend = m_pend | setv;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_dly = '0;
      m_busy = 0;  m_gap = 0;
      m_cur = 0;   m_vec = 0; m_last = 31; m_err = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("req", int'(app_msi_req), int'(m_busy));
    if (m_busy) chk("num", int'(app_msi_num), m_vec);
    chk("err_count", int'(msi_err_count), m_err);
    chk("func_num", int'(app_msi_func_num), 2);
    chk("tc", int'(app_msi_tc), 5);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] bits);
    msi_irq = msi_irq | bits;
    tick();
    msi_irq = msi_irq & ~bits;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!app_msi_req && n < 200) begin
      tick();
      n++;
    end
    if (!app_msi_req) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic send_ack(input int exp_num, input logic [1:0] st);
    wait_req("send");
    chk("sent_vector", int'(app_msi_num), exp_num);
    app_msi_ack    = 1'b1;
    app_msi_status = st;
    tick();
    app_msi_ack    = 1'b0;
    app_msi_status = 2'b00;
    chk("gap_req_low", int'(app_msi_req), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bit bad;
    bit got;

    #2;
    chk("reset_req", int'(app_msi_req), 0);
    chk("reset_num", int'(app_msi_num), 0);
    chk("reset_err", int'(msi_err_count), 0);
    chk("reset_func", int'(app_msi_func_num), 2);
    chk("reset_tc", int'(app_msi_tc), 5);
    tick();
    rst_n = 1'b1;
    cfg_msi_enable = 1'b1;
    cfg_multiple_msi_enable = 3'd5;
    cfg_msi_mask = '0;
    repeat (3) tick();

    // Latency: edge in cycle N gives req in N+3.
    pulse(32'h0000_0008);
    tick();
    chk("lat_n2_req", int'(app_msi_req), 0);
    tick();
    chk("lat_n3_req", int'(app_msi_req), 1);
    chk("lat_n3_num", int'(app_msi_num), 3);
    send_ack(3, 2'b00);
    repeat (5) tick();
    chk("cleared_no_resend", int'(app_msi_req), 0);

    // Round-robin from reset, then wrap past 30.
    do_reset();
    pulse(32'h4000_0006);
    send_ack(1, 2'b00);
    send_ack(2, 2'b00);
    send_ack(30, 2'b00);
    pulse(32'h0000_0006);
    send_ack(1, 2'b00);
    send_ack(2, 2'b00);

    // Four vectors: source 13 folds onto vector 1.
    cfg_multiple_msi_enable = 3'd2;
    pulse(32'h0000_2000);
    send_ack(1, 2'b00);
    cfg_multiple_msi_enable = 3'd5;

    // Masked source stays pending until unmasked.
    cfg_msi_mask = 32'h0000_0020;
    pulse(32'h0000_0020);
    bad = 0;
    repeat (100) begin
      tick();
      if (app_msi_req) bad = 1;
    end
    chk("masked_no_req", int'(bad), 0);
    cfg_msi_mask = '0;
    got = 0;
    repeat (3) begin
      tick();
      if (app_msi_req && !got) begin
        got = 1;
        chk("unmask_vector", int'(app_msi_num), 5);
      end
    end
    chk("unmask_within_3", int'(got), 1);
    send_ack(5, 2'b00);

    // Error acks re-send the vector.
    pulse(32'h0000_0080);
    send_ack(7, 2'b10);
    send_ack(7, 2'b10);
    chk("err_after_two", int'(msi_err_count), 2);
    send_ack(7, 2'b00);
    chk("err_after_ok", int'(msi_err_count), 2);
    repeat (4) tick();
    chk("err_vec_cleared", int'(app_msi_req), 0);

    // Saturation of the error counter.
    pulse(32'h0000_0001);
    repeat (260) send_ack(0, 2'b01);
    chk("err_saturated", int'(msi_err_count), 255);
    send_ack(0, 2'b00);

    // Enable drop does not withdraw an outstanding request.
    pulse(32'h0000_0200);
    wait_req("en_drop");
    cfg_msi_enable = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (!app_msi_req) bad = 1;
    end
    chk("req_held_en_low", int'(bad), 0);
    send_ack(9, 2'b00);
    cfg_msi_enable = 1'b1;

    // Asynchronous reset mid-request.
    pulse(32'h0000_0400);
    wait_req("rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", int'(app_msi_req), 0);
    chk("async_rst_err", int'(msi_err_count), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("lost_after_rst", int'(app_msi_req), 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      msi_irq = msi_irq ^ ($urandom & $urandom & $urandom & $urandom);
      cfg_msi_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) cfg_multiple_msi_enable = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) cfg_msi_mask = $urandom & $urandom & $urandom;
      app_msi_ack = ($urandom_range(0, 3) == 0);
      app_msi_status = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick();
    end
    app_msi_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
